leading_count_pipe: RTL and testbench

LEADING_COUNT_PIPE -- requirements
Module: leading_count_pipe

---
 rtl/leading_count_pipe.sv | 115 +++++++++++
 tb/tb_leading_count_pipe.sv | 399 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/leading_count_pipe.sv
// Leading zero/one counter behind an elastic pipeline of STAGES slots.
// The scan happens at entry; the slots carry finished results toward the output.
module leading_count_pipe #(
    parameter int WIDTH      = 16,
    parameter int ADD_OFFSET = 0,
    parameter int STAGES     = 2,
    parameter int TAG_WIDTH  = 1,
    localparam int CW        = $clog2(WIDTH + 1 + ADD_OFFSET)
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 inValid,
    output logic                 inReady,
    input  logic [WIDTH-1:0]     in,
    input  logic                 inMode,
    input  logic [TAG_WIDTH-1:0] inTag,
    output logic                 outValid,
    input  logic                 outReady,
    output logic [CW-1:0]        outCount,
    output logic [WIDTH-1:0]     outNorm,
    output logic                 outAllSame,
    output logic [TAG_WIDTH-1:0] outTag
);

    logic [CW-1:0]        rawCount;
    logic                 runOpen;
    logic [CW-1:0]        entryCount;
    logic [WIDTH-1:0]     entryNorm;
    logic                 entryAllSame;

    logic [STAGES-1:0]    validQ;
    logic [STAGES-1:0]    validD;
    logic [STAGES-1:0]    slotReady;
    logic [CW-1:0]        countQ   [STAGES];
    logic [WIDTH-1:0]     normQ    [STAGES];
    logic                 allSameQ [STAGES];
    logic [TAG_WIDTH-1:0] tagQ     [STAGES];

    // The run stops at the first bit that differs from the counted digit.
    always_comb begin
        rawCount = '0;
        runOpen  = 1'b1;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (runOpen && (in[i] == inMode)) begin
                rawCount = rawCount + CW'(1);
            end else begin
                runOpen = 1'b0;
            end
        end
        entryCount   = rawCount + CW'(ADD_OFFSET);
        entryNorm    = in << rawCount;
        entryAllSame = (rawCount == CW'(WIDTH));
    end

    // A slot may load when it or any slot after it is empty, or the output drains.
    always_comb begin
        logic downstreamOpen;
        downstreamOpen = outReady;
        slotReady      = '0;
        for (int k = STAGES - 1; k >= 0; k--) begin
            downstreamOpen = downstreamOpen || !validQ[k];
            slotReady[k]   = downstreamOpen;
        end
    end

    assign inReady = slotReady[0] && !reset;

    always_comb begin
        validD = validQ;
        if (slotReady[0]) begin
            validD[0] = inValid && inReady;
        end
        for (int k = 1; k < STAGES; k++) begin
            if (slotReady[k]) begin
                validD[k] = validQ[k-1];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            validQ <= '0;
            for (int k = 0; k < STAGES; k++) begin
                countQ[k]   <= '0;
                normQ[k]    <= '0;
                allSameQ[k] <= 1'b0;
                tagQ[k]     <= '0;
            end
        end else begin
            validQ <= validD;
            if (slotReady[0]) begin
                countQ[0]   <= entryCount;
                normQ[0]    <= entryNorm;
                allSameQ[0] <= entryAllSame;
                tagQ[0]     <= inTag;
            end
            for (int k = 1; k < STAGES; k++) begin
                if (slotReady[k]) begin
                    countQ[k]   <= countQ[k-1];
                    normQ[k]    <= normQ[k-1];
                    allSameQ[k] <= allSameQ[k-1];
                    tagQ[k]     <= tagQ[k-1];
                end
            end
        end
    end

    // Outputs read as zero while reset is held, even before the first clearing edge.
    assign outValid   = validQ[STAGES-1] && !reset;
    assign outCount   = reset ? '0 : countQ[STAGES-1];
    assign outNorm    = reset ? '0 : normQ[STAGES-1];
    assign outAllSame = allSameQ[STAGES-1] && !reset;
    assign outTag     = reset ? '0 : tagQ[STAGES-1];

endmodule

// File: tb/tb_leading_count_pipe.sv
// Directed and randomized checks of leading_count_pipe across several parameter sets.
module tb_leading_count_pipe;

    logic clock;
    logic reset;
    int   checks;
    int   errors;

    // Main instance: WIDTH 16, STAGES 2, ADD_OFFSET 0, TAG_WIDTH 1
    logic        inValid, inReady, inMode, outValid, outReady, outAllSame;
    logic [15:0] dataIn, outNorm;
    logic [0:0]  inTag, outTag;
    logic [4:0]  outCount;

    // Offset instance shares the main inputs
    logic        offInReady, offOutValid, offAllSame;
    logic [4:0]  offCount;
    logic [15:0] offNorm;
    logic [0:0]  offTag;

    // Small instance: WIDTH 5, STAGES 1
    logic        sInValid, sInReady, sMode, sOutValid, sOutReady, sAllSame;
    logic [4:0]  sIn, sNorm;
    logic [2:0]  sTag, sOutTag, sCount;

    // Random instance: WIDTH 23, STAGES 4, ADD_OFFSET 2, TAG_WIDTH 4
    logic        rInValid, rInReady, rMode, rOutValid, rOutReady, rAllSame;
    logic [22:0] rIn, rNorm;
    logic [3:0]  rTag, rOutTag;
    logic [4:0]  rCount;

    leading_count_pipe #(.WIDTH(16), .ADD_OFFSET(0), .STAGES(2), .TAG_WIDTH(1)) dut (
        .clock(clock), .reset(reset), .inValid(inValid), .inReady(inReady),
        .in(dataIn), .inMode(inMode), .inTag(inTag), .outValid(outValid),
        .outReady(outReady), .outCount(outCount), .outNorm(outNorm),
        .outAllSame(outAllSame), .outTag(outTag));

    leading_count_pipe #(.WIDTH(16), .ADD_OFFSET(1), .STAGES(2), .TAG_WIDTH(1)) dutOff (
        .clock(clock), .reset(reset), .inValid(inValid), .inReady(offInReady),
        .in(dataIn), .inMode(inMode), .inTag(inTag), .outValid(offOutValid),
        .outReady(outReady), .outCount(offCount), .outNorm(offNorm),
        .outAllSame(offAllSame), .outTag(offTag));

    leading_count_pipe #(.WIDTH(5), .ADD_OFFSET(0), .STAGES(1), .TAG_WIDTH(3)) dutSmall (
        .clock(clock), .reset(reset), .inValid(sInValid), .inReady(sInReady),
        .in(sIn), .inMode(sMode), .inTag(sTag), .outValid(sOutValid),
        .outReady(sOutReady), .outCount(sCount), .outNorm(sNorm),
        .outAllSame(sAllSame), .outTag(sOutTag));

    leading_count_pipe #(.WIDTH(23), .ADD_OFFSET(2), .STAGES(4), .TAG_WIDTH(4)) dutRand (
        .clock(clock), .reset(reset), .inValid(rInValid), .inReady(rInReady),
        .in(rIn), .inMode(rMode), .inTag(rTag), .outValid(rOutValid),
        .outReady(rOutReady), .outCount(rCount), .outNorm(rNorm),
        .outAllSame(rAllSame), .outTag(rOutTag));

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        inValid = 1'b1; dataIn = 16'h0F00; inMode = 1'b0; inTag = 1'b1; outReady = 1'b1;
        sInValid = 1'b1; sIn = 5'b00110; sMode = 1'b0; sTag = 3'd3; sOutReady = 1'b1;
        rInValid = 1'b1; rIn = 23'h1; rMode = 1'b0; rTag = 4'h5; rOutReady = 1'b1;
        repeat (2) @(posedge clock);
        @(negedge clock);
        checks++;
        if ({outValid, inReady, outCount, outNorm, outAllSame, outTag} !== 24'h0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got %h expected 000000",
                     {outValid, inReady, outCount, outNorm, outAllSame, outTag});
        end
        checks++;
        if ({sInReady, sOutValid, rInReady, rOutValid} !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL reset_other_instances: got %b expected 0000",
                     {sInReady, sOutValid, rInReady, rOutValid});
        end
        tick();
        reset = 1'b0; inValid = 1'b0; sInValid = 1'b0; rInValid = 1'b0;
        @(negedge clock);
        checks++;
        if ({inReady, offInReady, sInReady, rInReady} !== 4'b1111) begin
            errors++;
            $display("[TB] FAIL reset_release_ready: got %b expected 1111",
                     {inReady, offInReady, sInReady, rInReady});
        end
        for (int c = 0; c < 5; c++) begin
            checks++;
            if ({outValid, offOutValid, sOutValid, rOutValid} !== 4'b0000) begin
                errors++;
                $display("[TB] FAIL reset_input_dropped[%0d]: got %b expected 0000",
                         c, {outValid, offOutValid, sOutValid, rOutValid});
            end
            @(negedge clock);
        end
    endtask

    task automatic test_basic();
        logic [15:0] vData  [7] = '{16'h0F00, 16'h0000, 16'hE800, 16'h8000, 16'hFFFF, 16'h0001, 16'hFFFF};
        logic        vMode  [7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        logic        vTag   [7] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        logic [4:0]  vCount [7] = '{5'd4, 5'd16, 5'd3, 5'd0, 5'd16, 5'd15, 5'd0};
        logic [15:0] vNorm  [7] = '{16'hF000, 16'h0000, 16'h4000, 16'h8000, 16'h0000, 16'h8000, 16'hFFFF};
        logic        vAll   [7] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        outReady = 1'b1;
        for (int v = 0; v < 7; v++) begin
            tick();
            inValid = 1'b1; dataIn = vData[v]; inMode = vMode[v]; inTag = vTag[v];
            @(negedge clock);
            checks++;
            if ({inReady, offInReady} !== 2'b11) begin
                errors++;
                $display("[TB] FAIL basic_inready[%0d]: got %b expected 11", v, {inReady, offInReady});
            end
            tick();
            inValid = 1'b0;
            @(negedge clock);
            checks++;
            if (outValid !== 1'b0) begin
                errors++;
                $display("[TB] FAIL basic_early[%0d]: outValid got %b expected 0", v, outValid);
            end
            tick();
            @(negedge clock);
            checks++;
            if ({outValid, outCount, outNorm, outAllSame, outTag} !==
                {1'b1, vCount[v], vNorm[v], vAll[v], vTag[v]}) begin
                errors++;
                $display("[TB] FAIL basic_result[%0d]: got %h expected %h", v,
                         {outValid, outCount, outNorm, outAllSame, outTag},
                         {1'b1, vCount[v], vNorm[v], vAll[v], vTag[v]});
            end
            checks++;
            if ({offOutValid, offCount, offNorm, offAllSame, offTag} !==
                {1'b1, vCount[v] + 5'd1, vNorm[v], vAll[v], vTag[v]}) begin
                errors++;
                $display("[TB] FAIL offset_result[%0d]: got %h expected %h", v,
                         {offOutValid, offCount, offNorm, offAllSame, offTag},
                         {1'b1, vCount[v] + 5'd1, vNorm[v], vAll[v], vTag[v]});
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] bData  [5] = '{16'h1234, 16'hF0F0, 16'h0003, 16'h7FFF, 16'hC000};
        logic        bMode  [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        logic        bTag   [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        logic [4:0]  bCount [5] = '{5'd3, 5'd4, 5'd14, 5'd1, 5'd2};
        logic [15:0] bNorm  [5] = '{16'h91A0, 16'h0F00, 16'hC000, 16'hFFFE, 16'h0000};
        outReady = 1'b1;
        for (int c = 0; c < 7; c++) begin
            tick();
            inValid = (c < 5);
            if (c < 5) begin
                dataIn = bData[c]; inMode = bMode[c]; inTag = bTag[c];
            end
            @(negedge clock);
            if (c < 5) begin
                checks++;
                if (inReady !== 1'b1) begin
                    errors++;
                    $display("[TB] FAIL b2b_inready[%0d]: got %b expected 1", c, inReady);
                end
            end
            checks++;
            if (c < 2) begin
                if (outValid !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL b2b_idle[%0d]: outValid got %b expected 0", c, outValid);
                end
            end else if ({outValid, outCount, outNorm, outAllSame, outTag} !==
                         {1'b1, bCount[c-2], bNorm[c-2], 1'b0, bTag[c-2]}) begin
                errors++;
                $display("[TB] FAIL b2b_result[%0d]: got %h expected %h", c,
                         {outValid, outCount, outNorm, outAllSame, outTag},
                         {1'b1, bCount[c-2], bNorm[c-2], 1'b0, bTag[c-2]});
            end
        end
        tick();
        inValid = 1'b0;
    endtask

    task automatic test_backpressure();
        logic [15:0] pData  [6] = '{16'h0F00, 16'h00FF, 16'hFF00, 16'h0800, 16'hAAAA, 16'h0001};
        logic        pMode  [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        logic        pTag   [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        logic [4:0]  pCount [6] = '{5'd4, 5'd8, 5'd8, 5'd4, 5'd1, 5'd0};
        logic [15:0] pNorm  [6] = '{16'hF000, 16'hFF00, 16'h0000, 16'h8000, 16'h5554, 16'h0001};
        int  sendIdx;
        int  outIdx;
        logic accepted;
        sendIdx = 0;
        for (int c = 0; c < 12; c++) begin
            tick();
            outReady = (c >= 5);
            inValid  = (sendIdx < 6);
            if (sendIdx < 6) begin
                dataIn = pData[sendIdx]; inMode = pMode[sendIdx]; inTag = pTag[sendIdx];
            end
            @(negedge clock);
            if (sendIdx < 6) begin
                checks++;
                if (inReady !== ((c < 2) || (c >= 5))) begin
                    errors++;
                    $display("[TB] FAIL bp_inready[%0d]: got %b expected %b", c, inReady,
                             ((c < 2) || (c >= 5)));
                end
            end
            outIdx = (c < 5) ? 0 : c - 5;
            checks++;
            if (c < 2 || outIdx >= 6) begin
                if (outValid !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL bp_idle[%0d]: outValid got %b expected 0", c, outValid);
                end
            end else if ({outValid, outCount, outNorm, outAllSame, outTag} !==
                         {1'b1, pCount[outIdx], pNorm[outIdx], 1'b0, pTag[outIdx]}) begin
                errors++;
                $display("[TB] FAIL bp_result[%0d]: got %h expected %h", c,
                         {outValid, outCount, outNorm, outAllSame, outTag},
                         {1'b1, pCount[outIdx], pNorm[outIdx], 1'b0, pTag[outIdx]});
            end
            accepted = inValid && inReady;
            if (accepted) sendIdx++;
        end
        checks++;
        if (sendIdx != 6) begin
            errors++;
            $display("[TB] FAIL bp_accept_count: got %0d expected 6", sendIdx);
        end
        tick();
        inValid = 1'b0; outReady = 1'b1;
    endtask

    task automatic test_reset_midstream();
        outReady = 1'b1;
        tick();
        inValid = 1'b1; dataIn = 16'h00F0; inMode = 1'b0; inTag = 1'b1;
        tick();
        dataIn = 16'h3C00;
        tick();
        inValid = 1'b0; reset = 1'b1;
        @(negedge clock);
        checks++;
        if ({outValid, inReady} !== 2'b00) begin
            errors++;
            $display("[TB] FAIL midreset_during: got %b expected 00", {outValid, inReady});
        end
        tick();
        reset = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clock);
            checks++;
            if (outValid !== 1'b0) begin
                errors++;
                $display("[TB] FAIL midreset_flushed[%0d]: outValid got %b expected 0", c, outValid);
            end
            if (c < 3) tick();
        end
        tick();
        inValid = 1'b1; dataIn = 16'h0030; inMode = 1'b0; inTag = 1'b0;
        tick();
        inValid = 1'b0;
        @(negedge clock);
        checks++;
        if (outValid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL midreset_early: outValid got %b expected 0", outValid);
        end
        tick();
        @(negedge clock);
        checks++;
        if ({outValid, outCount, outNorm, outAllSame, outTag} !==
            {1'b1, 5'd10, 16'hC000, 1'b0, 1'b0}) begin
            errors++;
            $display("[TB] FAIL midreset_next: got %h expected %h",
                     {outValid, outCount, outNorm, outAllSame, outTag},
                     {1'b1, 5'd10, 16'hC000, 1'b0, 1'b0});
        end
    endtask

    task automatic test_small();
        logic [4:0] tData  [3] = '{5'b00110, 5'b11111, 5'b10000};
        logic       tMode  [3] = '{1'b0, 1'b1, 1'b1};
        logic [2:0] tTag   [3] = '{3'd3, 3'd5, 3'd6};
        logic [2:0] tCount [3] = '{3'd2, 3'd5, 3'd1};
        logic [4:0] tNorm  [3] = '{5'b11000, 5'b00000, 5'b00000};
        logic       tAll   [3] = '{1'b0, 1'b1, 1'b0};
        sOutReady = 1'b1;
        for (int v = 0; v < 3; v++) begin
            tick();
            sInValid = 1'b1; sIn = tData[v]; sMode = tMode[v]; sTag = tTag[v];
            @(negedge clock);
            checks++;
            if ({sInReady, sOutValid} !== 2'b10) begin
                errors++;
                $display("[TB] FAIL small_before[%0d]: got %b expected 10", v, {sInReady, sOutValid});
            end
            tick();
            sInValid = 1'b0;
            @(negedge clock);
            checks++;
            if ({sOutValid, sCount, sNorm, sAllSame, sOutTag} !==
                {1'b1, tCount[v], tNorm[v], tAll[v], tTag[v]}) begin
                errors++;
                $display("[TB] FAIL small_result[%0d]: got %h expected %h", v,
                         {sOutValid, sCount, sNorm, sAllSame, sOutTag},
                         {1'b1, tCount[v], tNorm[v], tAll[v], tTag[v]});
            end
        end
    endtask

    function automatic logic [32:0] refRand(input logic [22:0] d, input logic m, input logic [3:0] t);
        int   n;
        logic run;
        logic [22:0] norm;
        n   = 0;
        run = 1'b1;
        for (int i = 22; i >= 0; i--) begin
            if (run && d[i] == m) n++;
            else run = 1'b0;
        end
        norm = (n == 23) ? 23'h0 : (d << n);
        return {5'(n + 2), norm, (n == 23), t};
    endfunction

    task automatic test_random();
        logic [32:0] expQ [$];
        logic [32:0] expItem;
        logic [22:0] v;
        int popped;
        popped = 0;
        for (int c = 0; c < 640; c++) begin
            tick();
            if (c < 600) begin
                rInValid  = ($urandom_range(0, 3) != 0);
                rOutReady = ($urandom_range(0, 3) != 0);
                rMode     = 1'($urandom);
                v         = 23'($urandom) >> $urandom_range(0, 23);
                rIn       = rMode ? ~v : v;
                rTag      = 4'($urandom);
            end else begin
                rInValid  = 1'b0;
                rOutReady = 1'b1;
            end
            @(negedge clock);
            if (rOutValid && rOutReady) begin
                checks++;
                if (expQ.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL rand_extra[%0d]: got %h expected no item", c,
                             {rCount, rNorm, rAllSame, rOutTag});
                end else begin
                    expItem = expQ.pop_front();
                    popped++;
                    if ({rCount, rNorm, rAllSame, rOutTag} !== expItem) begin
                        errors++;
                        $display("[TB] FAIL rand_result[%0d]: got %h expected %h", popped,
                                 {rCount, rNorm, rAllSame, rOutTag}, expItem);
                    end
                end
            end
            if (rInValid && rInReady) begin
                expQ.push_back(refRand(rIn, rMode, rTag));
            end
        end
        checks++;
        if (expQ.size() != 0 || popped == 0) begin
            errors++;
            $display("[TB] FAIL rand_drain: left %0d popped %0d expected left 0", expQ.size(), popped);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_basic();
        test_back_to_back();
        test_backpressure();
        test_reset_midstream();
        test_small();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
